m_mux4way_arb: RTL
==================

# m_mux4way_arb

Four-channel to one-channel stream merger with a registered output stage; the converse of the 4-way demultiplexer. It collects 16-bit words from four independent producers over valid/ready handshakes, arbitrates round-robin, and presents one word at a time to a single consumer, tagged with its source channel. It sits in front of a shared single-port resource (e.g. a bus or memory write port) that several datapath units must reach.

## Interface
Parameters:
- `WIDTH`, 16, data width of every channel.

Ports:
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  4  per-channel request; bit k belongs to channel k.
- `i_data`  in  4*WIDTH  channel k occupies `[k*WIDTH +: WIDTH]`.
- `o_ready`  out  4  per-channel accept; combinational, at most one bit set (one-hot or zero).
- `o_valid`  out  1  output word valid.
- `o_data`  out  WIDTH  output word.
- `o_sel`  out  2  index of the channel that produced `o_data`.
- `i_ready`  in  1  consumer accepts the output word.
- `i_last`  in  4  only with `MUX4WAY_PKT_LOCK_EN`; end-of-packet flag per channel.
- `o_last`  out  1  only with `MUX4WAY_PKT_LOCK_EN`; registered copy of the selected `i_last` bit.

## Operation
- One output register holding `o_valid`, `o_data`, `o_sel` (and `o_last`).
- Load enable: `load = !o_valid || i_ready`.
- Grant: when `load` is set and any `i_valid` bit is set, pick the first valid channel searching `ptr+1, ptr+2, ptr+3, ptr` (mod 4), where `ptr` is the last granted channel.
- `o_ready[g] = 1` for the granted channel g only. A transfer on channel g occurs when `i_valid[g] && o_ready[g]`.
- On a transfer: the register captures `i_data[g]` and g, `o_valid` is set to 1, and `ptr` is set to g.
- When `load` is set and no input is valid, `o_valid` is set to 0; `o_data` and `o_sel` hold their values.
- When `load` is clear, the register and `ptr` hold, and `o_ready` is 0.
- Output rule: `o_data` and `o_sel` stay stable while `o_valid && !i_ready`.
- Reset values: `o_valid=0`, `o_data=0`, `o_sel=0`, `o_last=0`, `ptr=3`, so channel 0 has first priority after reset.
- Reset has priority over everything else. A word held mid-transfer is discarded and nothing is granted in the reset cycle.
- Producers must hold `i_valid` and `i_data` until accepted. `o_ready` never depends on the same channel's own data.

## Timing
- Latency: 1 cycle from an input transfer to `o_valid` with that word.
- Throughput: 1 word per cycle while `i_ready` is held high. `o_ready` and `i_ready` may both be high in the same cycle (pass-through pipelining).
- Combinational path: `i_ready` and `i_valid` to `o_ready`. There is no combinational path from `i_data` to `o_data`.
- Fairness: with all four channels continuously valid and `i_ready=1`, grants follow 0,1,2,3,0,…, one per cycle.

## Configuration
- `MUX4WAY_PKT_LOCK_EN` defined:
  - Adds the `i_last` input and the `o_last` output.
  - After a transfer with `i_last[g]=0`, the grant is locked to g. Other channels are not served, even if g drops `i_valid`.
  - A transfer with `i_last[g]=1` releases the lock and round-robin resumes from g+1.
  - The lock clears on reset.
- Undefined:
  - No `i_last` or `o_last` ports.
  - Arbitration happens on every word as described in Operation.

## Test plan
- Reset check: hold `i_rst=1` for 2 cycles with all channels valid. Required: `o_valid=0`, `o_data=0`, `o_sel=0`, `o_ready=0000`. On the first cycle after reset, `o_ready=0001`.
- Single channel: channel 2 sends 0x1234 with `i_ready=1`. Required: one cycle later `o_valid=1`, `o_data=0x1234`, `o_sel=2`. The next cycle `o_valid=0`.
- Round-robin: all channels valid with data 0xA000+k, `i_ready=1`. Required: `o_sel` sequence 0,1,2,3,0 on consecutive cycles, each with the matching data.
- Backpressure: load 0xBEEF from channel 1, then hold `i_ready=0` for 5 cycles with channel 3 valid. Required: `o_data=0xBEEF` and `o_sel=1` stable, `o_ready=0000`. Release `i_ready`: in that same cycle channel 3 is accepted, and the next cycle shows `o_sel=3`.
- Reset mid-operation: hold `o_valid=1` with `i_ready=0`, then assert `i_rst`. Required: `o_valid=0` the next cycle and the word is lost. After reset, channel 0 wins over channels 1–3.
- With `MUX4WAY_PKT_LOCK_EN`: channel 1 sends 3 words, last on the third, while channel 2 is valid throughout. Required: `o_sel` reads 1,1,1, then 2. `o_last=1` only on the third word.

Source files
------------

// File: rtl/m_mux4way_arb.sv
// m_mux4way_arb: 4-to-1 round-robin stream merger with a registered output.
// Ports: i_clk, i_rst (sync, active-high); i_valid/i_data/o_ready per channel;
// o_valid/o_data/o_sel/i_ready toward the consumer.
// Option MUX4WAY_PKT_LOCK_EN adds i_last/o_last and holds the grant for a packet.
module m_mux4way_arb #(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [3:0]         i_valid,
  input  logic [4*WIDTH-1:0] i_data,
  output logic [3:0]         o_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [1:0]         o_sel,
  input  logic               i_ready
`ifdef MUX4WAY_PKT_LOCK_EN
  ,
  input  logic [3:0]         i_last,
  output logic               o_last
`endif
);

  logic [WIDTH-1:0] ch_data [4];
  logic [1:0]       ptr_q;
  logic             load;
  logic             gnt_found;
  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic             xfer;

`ifdef MUX4WAY_PKT_LOCK_EN
  logic             lock_q;
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ch_data[k] = i_data[k*WIDTH +: WIDTH];
    end
  end

  assign load = !o_valid || i_ready;

  // Search ptr+1 .. ptr+4 so the last winner has the lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_found && i_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`ifdef MUX4WAY_PKT_LOCK_EN
    // Inside a packet only the owning channel may be served.
    if (lock_q) begin
      gnt_found = i_valid[ptr_q];
      gnt_idx   = ptr_q;
    end
`endif
  end

  always_comb begin
    o_ready = 4'b0000;
    if (load && gnt_found && !i_rst) begin
      o_ready = 4'b0001 << gnt_idx;
    end
  end

  assign xfer = |o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sel   <= 2'd0;
      ptr_q   <= 2'd3;
`ifdef MUX4WAY_PKT_LOCK_EN
      o_last  <= 1'b0;
      lock_q  <= 1'b0;
`endif
    end else if (load) begin
      if (xfer) begin
        o_valid <= 1'b1;
        o_data  <= ch_data[gnt_idx];
        o_sel   <= gnt_idx;
        ptr_q   <= gnt_idx;
`ifdef MUX4WAY_PKT_LOCK_EN
        o_last  <= i_last[gnt_idx];
        lock_q  <= !i_last[gnt_idx];
`endif
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
